// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: video (8b/10b with DC balance), control, TERC4 data-island and guard-band symbols.
// Optional macro TMDS_OUTPUT_REG_EN adds a second output register (latency 2 instead of 1).
module tmds_channel_encoder #(
    parameter int CN = 0
) (
    input  logic       clk_pixel_i,
    input  logic       reset_i,
    input  logic [2:0] mode_i,
    input  logic [7:0] video_data_i,
    input  logic [3:0] data_island_data_i,
    input  logic [1:0] control_data_i,
    output logic [9:0] tmds_o
);
    localparam logic [9:0] CTRL_00  = 10'b1101010100;
    localparam logic [9:0] CTRL_01  = 10'b0010101011;
    localparam logic [9:0] CTRL_10  = 10'b0101010100;
    localparam logic [9:0] CTRL_11  = 10'b1010101011;
    localparam logic [9:0] GB_VID02 = 10'b1011001100;
    localparam logic [9:0] GB_LANE1 = 10'b0100110011;

    function automatic logic [9:0] terc4(input logic [3:0] n);
        logic [9:0] s;
        case (n)
            4'h0: s = 10'b1010011100;  4'h1: s = 10'b1001100011;
            4'h2: s = 10'b1011100100;  4'h3: s = 10'b1011100010;
            4'h4: s = 10'b0101110001;  4'h5: s = 10'b0100011110;
            4'h6: s = 10'b0110001110;  4'h7: s = 10'b0100111100;
            4'h8: s = 10'b1011001100;  4'h9: s = 10'b0100111001;
            4'hA: s = 10'b0110011100;  4'hB: s = 10'b1011000110;
            4'hC: s = 10'b1010001110;  4'hD: s = 10'b1001110001;
            4'hE: s = 10'b0101100011;  default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    // Transition minimisation: XOR chain, or XNOR chain when the byte is ones-heavy.
    function automatic logic [8:0] stage1(input logic [7:0] d);
        logic [3:0] n1d;
        logic       use_xnor;
        logic [8:0] q;
        n1d      = ones8(d);
        use_xnor = (n1d > 4'd4) | ((n1d == 4'd4) & ~d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i] ^ use_xnor;
        q[8]     = ~use_xnor;
        return q;
    endfunction

    logic [8:0]        q_m;
    logic [3:0]        n1, n0;
    logic signed [4:0] diff;
    logic signed [4:0] cnt_q, cnt_d, cnt_video;
    logic [9:0]        video_sym;
    logic [9:0]        tmds_q, tmds_d;

    always_comb begin
        q_m  = stage1(video_data_i);
        n1   = ones8(q_m[7:0]);
        n0   = 4'd8 - n1;
        diff = $signed({1'b0, n1}) - $signed({1'b0, n0});
    end

    // DC balance against the running disparity.
    always_comb begin
        video_sym = '0;
        cnt_video = cnt_q;
        if (cnt_q == 5'sd0 || n1 == n0) begin
            video_sym = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_video = q_m[8] ? cnt_q + diff : cnt_q - diff;
        end else if ((!cnt_q[4] && n1 > n0) || (cnt_q[4] && n0 > n1)) begin
            video_sym = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_video = cnt_q + $signed({3'b000, q_m[8], 1'b0}) - diff;
        end else begin
            video_sym = {1'b0, q_m[8], q_m[7:0]};
            cnt_video = cnt_q - $signed({3'b000, ~q_m[8], 1'b0}) + diff;
        end
    end

    always_comb begin
        tmds_d = CTRL_00;
        cnt_d  = 5'sd0;
        case (mode_i)
            3'd1: begin
                tmds_d = video_sym;
                cnt_d  = cnt_video;
            end
            3'd2: tmds_d = (CN == 1) ? GB_LANE1 : GB_VID02;
            3'd3: tmds_d = terc4(data_island_data_i);
            3'd4: tmds_d = (CN == 0) ? terc4({2'b11, control_data_i}) : GB_LANE1;
            default: begin
                case (control_data_i)
                    2'b00:   tmds_d = CTRL_00;
                    2'b01:   tmds_d = CTRL_01;
                    2'b10:   tmds_d = CTRL_10;
                    default: tmds_d = CTRL_11;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk_pixel_i) begin
        if (reset_i) begin
            tmds_q <= CTRL_00;
            cnt_q  <= 5'sd0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef TMDS_OUTPUT_REG_EN
    logic [9:0] tmds_out_q;

    always_ff @(posedge clk_pixel_i) begin
        if (reset_i) tmds_out_q <= CTRL_00;
        else         tmds_out_q <= tmds_q;
    end

    assign tmds_o = tmds_out_q;
`else
    assign tmds_o = tmds_q;
`endif
endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: three lanes (CN=0,1,2) share stimulus;
// a high-level reference model predicts symbols and running disparity.
module tb_tmds_channel_encoder;
`ifdef TMDS_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode = 3'd0;
    logic [7:0] vd = 8'h00;
    logic [3:0] nib = 4'h0;
    logic [1:0] ctrl = 2'b00;
    logic [9:0] tmds0, tmds1, tmds2;

    always #5 clk = ~clk;

    tmds_channel_encoder #(.CN(0)) dut0 (.clk_pixel_i(clk), .reset_i(rst), .mode_i(mode),
        .video_data_i(vd), .data_island_data_i(nib), .control_data_i(ctrl), .tmds_o(tmds0));
    tmds_channel_encoder #(.CN(1)) dut1 (.clk_pixel_i(clk), .reset_i(rst), .mode_i(mode),
        .video_data_i(vd), .data_island_data_i(nib), .control_data_i(ctrl), .tmds_o(tmds1));
    tmds_channel_encoder #(.CN(2)) dut2 (.clk_pixel_i(clk), .reset_i(rst), .mode_i(mode),
        .video_data_i(vd), .data_island_data_i(nib), .control_data_i(ctrl), .tmds_o(tmds2));

    typedef struct {
        int         due;
        logic [9:0] e0, e1, e2;
        bit         vid;
        logic [7:0] d;
    } ent_t;
    typedef struct {
        int due;
        int c;
    } cnt_ent_t;

    ent_t     tq[$];
    cnt_ent_t cq[$];
    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;
    int       mcnt = 0;

    logic [9:0] terc4_tab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // Reference video encoder; updates the model disparity mcnt.
    function automatic logic [9:0] ref_video(input logic [7:0] d);
        int         ones, n1, n0;
        bit         use_xnor;
        logic [8:0] qm;
        logic [9:0] s;
        ones     = $countones(d);
        use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (mcnt == 0 || n1 == n0) begin
            s    = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt = mcnt + (qm[8] ? n1 - n0 : n0 - n1);
        end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
            s    = {1'b1, qm[8], ~qm[7:0]};
            mcnt = mcnt + 2 * int'(qm[8]) + n0 - n1;
        end else begin
            s    = {1'b0, qm[8], qm[7:0]};
            mcnt = mcnt - 2 * int'(!qm[8]) + n1 - n0;
        end
        return s;
    endfunction

    function automatic logic [9:0] ref_other(input int cn, input int m, input logic [1:0] c,
                                             input logic [3:0] n);
        case (m)
            2: return (cn == 1) ? 10'b0100110011 : 10'b1011001100;
            3: return terc4_tab[n];
            4: return (cn == 0) ? terc4_tab[{2'b11, c}] : 10'b0100110011;
            default: return ctrl_tab[c];
        endcase
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q, d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    task automatic step(input logic r, input int m, input logic [7:0] d,
                        input logic [3:0] n, input logic [1:0] c);
        ent_t     e;
        cnt_ent_t ce;
        @(posedge clk);
        #1;
        rst = r; mode = m[2:0]; vd = d; nib = n; ctrl = c;
        e.due = cyc + LAT; e.vid = 1'b0; e.d = d;
        if (r) begin
            e.e0 = ctrl_tab[0]; e.e1 = ctrl_tab[0]; e.e2 = ctrl_tab[0];
            mcnt = 0;
        end else if (m == 1) begin
            e.e0 = ref_video(d); e.e1 = e.e0; e.e2 = e.e0;
            e.vid = 1'b1;
        end else begin
            e.e0 = ref_other(0, m, c, n);
            e.e1 = ref_other(1, m, c, n);
            e.e2 = ref_other(2, m, c, n);
            mcnt = 0;
        end
        tq.push_back(e);
        ce.due = cyc + 1; ce.c = mcnt;
        cq.push_back(ce);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops whatever is due this cycle and compares against the live outputs.
    always @(negedge clk) begin
        ent_t     m;
        cnt_ent_t mc;
        int       act;
        while (tq.size() > 0 && tq[0].due <= cyc) begin
            m = tq.pop_front();
            checks += 3;
            if (tmds0 !== m.e0) begin errors++; $display("FAIL lane0 tmds cyc=%0d got=%b exp=%b", cyc, tmds0, m.e0); end
            if (tmds1 !== m.e1) begin errors++; $display("FAIL lane1 tmds cyc=%0d got=%b exp=%b", cyc, tmds1, m.e1); end
            if (tmds2 !== m.e2) begin errors++; $display("FAIL lane2 tmds cyc=%0d got=%b exp=%b", cyc, tmds2, m.e2); end
            if (m.vid) begin
                checks++;
                if (decode(tmds0) !== m.d) begin
                    errors++;
                    $display("FAIL decode cyc=%0d got=%h exp=%h", cyc, decode(tmds0), m.d);
                end
            end
        end
        while (cq.size() > 0 && cq[0].due <= cyc) begin
            mc  = cq.pop_front();
            act = int'($signed(dut0.cnt_q));
            checks += 2;
            if (act != mc.c) begin errors++; $display("FAIL cnt cyc=%0d got=%0d exp=%0d", cyc, act, mc.c); end
            if (act > 10 || act < -10) begin errors++; $display("FAIL cnt_bound cyc=%0d got=%0d exp=|cnt|<=10", cyc, act); end
        end
    end

    initial begin
        int m;
        // Reset held two cycles, then control 00.
        step(1, 0, 8'h00, 4'h0, 2'b00);
        step(1, 0, 8'h00, 4'h0, 2'b00);
        step(0, 0, 8'h00, 4'h0, 2'b00);
        // 0x00 twice: 0100000000 / cnt -8, then 1111111111 / cnt +2.
        step(0, 1, 8'h00, 4'h0, 2'b00);
        step(0, 1, 8'h00, 4'h0, 2'b00);
        for (int c = 0; c < 4; c++) step(0, 0, 8'h00, 4'h0, c[1:0]);
        step(0, 1, 8'hA5, 4'h0, 2'b00);
        step(0, 1, 8'hFF, 4'h0, 2'b00);
        for (int n = 0; n < 16; n++) step(0, 3, 8'h00, n[3:0], 2'b00);
        for (int c = 0; c < 4; c++) step(0, 4, 8'h00, 4'h0, c[1:0]);
        step(0, 2, 8'h00, 4'h0, 2'b00);
        for (int k = 5; k < 8; k++) step(0, k, 8'h00, 4'h0, 2'b11);
        step(0, 1, 8'h3C, 4'h0, 2'b00);
        step(1, 1, 8'h00, 4'h0, 2'b00);
        for (int i = 0; i < 10000; i++) begin
            m = ($urandom_range(0, 9) < 6) ? 1 : int'($urandom_range(0, 7));
            step(($urandom_range(0, 499) == 0), m, 8'($urandom), 4'($urandom), 2'($urandom));
        end
        step(0, 0, 8'h00, 4'h0, 2'b00);
        repeat (LAT + 3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (tq.size() != 0 || cq.size() != 0) begin
            errors++;
            $display("FAIL drain pending got=%0d exp=0", tq.size() + cq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
